key_serializer: RTL and testbench

- Companion-side transmitter for the serial key link: the other end of the chip's key deserializer.
- Samples 8 raw button pins, synchronizes and debounces them once per frame, then shifts a snapshot out MSB-first on skey.
- Shifting is paced by the chip's csync/pvalid outputs, so each bit is presented exactly when the chip samples it.
- Runs on the same 4 MHz clk as the chip.

---
 rtl/key_serializer.sv | 101 ++++++++++
 tb/tb_key_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_serializer.sv
// rtl/key_serializer.sv - serial key link transmitter; optional KEY_SERIALIZER_SOCD_EN
module key_serializer #(
    parameter int DEB_FRAMES = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn,
    input  logic       vsync,
    input  logic       csync,
    input  logic       pvalid,
    output logic       skey,
    output logic [7:0] key_state,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEB_FRAMES);

    logic [7:0]       sync_q1;
    logic [7:0]       sync_q2;
    logic             vsync_d;
    logic             tick;
    logic [7:0]       deb;
    logic [CNT_W-1:0] cnt [8];
    logic [7:0]       sr;
    logic [3:0]       bitcnt;

    // Two-flop synchronizer on the raw pins; idle level is released (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 8'hFF;
            sync_q2 <= 8'hFF;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Delayed vsync for frame-tick edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync;
        end
    end

    assign tick = vsync & ~vsync_d;

    // Per-key debounce: a differing level must be seen on DEB_FRAMES consecutive ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (sync_q2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] + 1'b1 == DEB_LIMIT) begin
                    deb[i] <= sync_q2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Presented key vector; with SOCD cleaning, opposing directions cancel to released.
    always_comb begin
        key_state = deb;
`ifdef KEY_SERIALIZER_SOCD_EN
        if (!deb[0] && !deb[1]) begin
            key_state[1:0] = 2'b11;
        end
        if (!deb[2] && !deb[3]) begin
            key_state[3:2] = 2'b11;
        end
`endif
    end

    // Shifter: csync (re)loads the snapshot, pvalid walks it out MSB-first, 1s fill behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= 8'hFF;
            bitcnt <= 4'd8;
        end else if (csync) begin
            sr     <= key_state;
            bitcnt <= 4'd0;
        end else if (pvalid && (bitcnt != 4'd8)) begin
            sr     <= {sr[6:0], 1'b1};
            bitcnt <= bitcnt + 4'd1;
        end
    end

    assign skey = sr[7];
    assign busy = (bitcnt != 4'd8);

endmodule

// File: tb/tb_key_serializer.sv
// tb/tb_key_serializer.sv - scoreboard bench for key_serializer
module tb_key_serializer;

    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn = 8'hFF;
    logic       vsync = 1'b0;
    logic       csync = 1'b0;
    logic       pvalid = 1'b0;
    logic       skey;
    logic [7:0] key_state;
    logic       busy;

    key_serializer #(.DEB_FRAMES(DEB), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .vsync(vsync),
        .csync(csync),
        .pvalid(pvalid),
        .skey(skey),
        .key_state(key_state),
        .busy(busy)
    );

    always #125 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] clean(input logic [7:0] d);
        logic [7:0] r;
        r = d;
`ifdef KEY_SERIALIZER_SOCD_EN
        if (!d[0] && !d[1]) r[1:0] = 2'b11;
        if (!d[2] && !d[3]) r[3:2] = 2'b11;
`endif
        return r;
    endfunction

    // Reference model state (frame-level view of the link)
    logic [7:0] m_deb = 8'hFF;
    logic [7:0] btn_q[$];
    bit         hist[8][$];
    logic       vs_prev = 1'b0;
    logic       cs_prev = 1'b0;
    int         sent = 8;
    logic [7:0] snap = 8'hFF;
    logic [7:0] sbq[$];

    task automatic model_step();
        logic [7:0] used;
        int run;
        if (rst) begin
            m_deb = 8'hFF;
            btn_q = '{8'hFF, 8'hFF};
            for (int i = 0; i < 8; i++) hist[i].delete();
            vs_prev = 1'b0;
            cs_prev = 1'b0;
            sent = 8;
            snap = 8'hFF;
            sbq.delete();
        end else begin
            used = btn_q[0];
            if (csync) begin
                snap = clean(m_deb);
                sent = 0;
            end else if (pvalid && sent < 8) begin
                sent++;
            end
            if (!csync && cs_prev) sbq.push_back(snap);
            cs_prev = csync;
            if (vsync && !vs_prev) begin
                for (int i = 0; i < 8; i++) begin
                    hist[i].push_back(used[i]);
                    if (hist[i].size() > 16) void'(hist[i].pop_front());
                    if (hist[i].size() >= DEB) begin
                        run = 0;
                        for (int j = 0; j < DEB; j++)
                            if (hist[i][hist[i].size() - 1 - j] != m_deb[i]) run++;
                        if (run == DEB) m_deb[i] = used[i];
                    end
                end
            end
            btn_q.push_back(btn);
            void'(btn_q.pop_front());
            vs_prev = vsync;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Receiver / monitor, sampling on the falling edge
    logic       rx_active = 1'b0;
    int         rx_nb = 0;
    logic [7:0] rx_word = 8'h00;
    logic       rx_cs_prev = 1'b0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] last_part = 8'h00;

    task automatic mon_step();
        logic [7:0] exp;
        if (rst) begin
            rx_active = 1'b0;
            rx_nb = 0;
            rx_word = 8'h00;
            rx_cs_prev = 1'b0;
        end else begin
            chk("key_state", key_state, clean(m_deb));
            chk("busy", {7'b0, busy}, {7'b0, (sent < 8)});
            if (csync) begin
                if (!rx_cs_prev && rx_active) begin
                    if (rx_nb > 0 && rx_nb < 8) begin
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL partial_word actual=%02h required=<no snapshot>", rx_word);
                        end else begin
                            exp = sbq.pop_front();
                            exp = exp >> (8 - rx_nb);
                            last_part = rx_word;
                            if (rx_word !== exp) begin
                                errors++;
                                $display("FAIL partial_word actual=%02h required=%02h", rx_word, exp);
                            end
                        end
                    end else if (rx_nb == 0 && sbq.size() > 0) begin
                        void'(sbq.pop_front());
                    end
                end
                rx_active = 1'b1;
                rx_nb = 0;
                rx_word = 8'h00;
            end else if (pvalid) begin
                if (rx_active && rx_nb < 8) begin
                    rx_word = {rx_word[6:0], skey};
                    rx_nb++;
                    if (rx_nb == 8) begin
                        last_rx = rx_word;
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL rx_word actual=%02h required=<no snapshot>", rx_word);
                        end else begin
                            exp = sbq.pop_front();
                            if (rx_word !== exp) begin
                                errors++;
                                $display("FAIL rx_word actual=%02h required=%02h", rx_word, exp);
                            end
                        end
                    end
                end else begin
                    chk("idle_skey", {7'b0, skey}, 8'h01);
                end
            end
            rx_cs_prev = csync;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon_step();
    end

    // Stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) step();
    endtask

    task automatic frame_tick();
        vsync = 1'b1;
        step();
        step();
        vsync = 1'b0;
        step();
        step();
    endtask

    task automatic window(input int n);
        csync = 1'b1;
        step();
        csync = 1'b0;
        for (int k = 0; k < n; k++) begin
            pvalid = 1'b1;
            step();
            pvalid = 1'b0;
            step();
        end
    endtask

    logic [7:0] exp_socd;

    initial begin
        repeat (3) step();
        chk("reset_skey", {7'b0, skey}, 8'h01);
        chk("reset_key_state", key_state, 8'hFF);
        chk("reset_busy", {7'b0, busy}, 8'h00);
        rst = 1'b0;
        step();

        for (int w = 0; w < 10; w++) window(12);
        chk("idle_key_state", key_state, 8'hFF);

        btn = 8'hA5;
        settle();
        frame_tick();
        chk("deb_tick1", key_state, 8'hFF);
        frame_tick();
        chk("deb_tick2", key_state, 8'hFF);
        frame_tick();
        chk("deb_tick3", key_state, 8'hA5);
        frame_tick();
        chk("deb_tick4", key_state, 8'hA5);
        window(8);
        chk("rx_a5", last_rx, 8'hA5);

        for (int g = 0; g < 3; g++) begin
            btn[0] = 1'b0;
            settle();
            frame_tick();
            btn[0] = 1'b1;
            settle();
            frame_tick();
        end
        chk("glitch_bit0", {7'b0, key_state[0]}, 8'h01);

        btn = 8'h3C;
        settle();
        repeat (3) frame_tick();
        chk("deb_3c", key_state, 8'h3C);
        window(4);
        window(8);
        chk("partial_3c", last_part, 8'h03);
        chk("rx_3c", last_rx, 8'h3C);

        btn = 8'h0F;
        settle();
        frame_tick();
        frame_tick();
        vsync = 1'b1;
        csync = 1'b1;
        step();
        csync = 1'b0;
        step();
        vsync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pvalid = 1'b1;
            step();
            pvalid = 1'b0;
            step();
        end
        chk("load_pre_tick", last_rx, 8'h3C);
        chk("post_tick_state", key_state, 8'h0F);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 119) == 0) btn = 8'($urandom);
            vsync = (c % 25) < 4;
            csync = ($urandom_range(0, 59) == 0);
            pvalid = ($urandom_range(0, 2) == 0);
            step();
        end
        vsync = 1'b0;
        csync = 1'b0;
        pvalid = 1'b0;
        step();

`ifdef KEY_SERIALIZER_SOCD_EN
        exp_socd = 8'hFF;
`else
        exp_socd = 8'hFC;
`endif
        btn = 8'hFC;
        settle();
        repeat (4) frame_tick();
        chk("socd_fc", key_state, exp_socd);
        window(8);
        chk("socd_rx", last_rx, exp_socd);
        btn = 8'hF6;
        settle();
        repeat (4) frame_tick();
        chk("socd_f6", key_state, 8'hF6);

        csync = 1'b1;
        step();
        csync = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pvalid = 1'b1;
            step();
            pvalid = 1'b0;
            step();
        end
        chk("pre_rst_busy", {7'b0, busy}, 8'h01);
        #50;
        rst = 1'b1;
        #1;
        chk("async_rst_skey", {7'b0, skey}, 8'h01);
        chk("async_rst_busy", {7'b0, busy}, 8'h00);
        chk("async_rst_key_state", key_state, 8'hFF);
        step();
        step();
        rst = 1'b0;
        step();
        window(8);
        chk("post_rst_rx", last_rx, 8'hFF);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
